// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, instruction opcodes, strobe bundle
// and the TAP transition/decode helpers used by the TAP, the TDO mux and the DR chains.
package jtag_pkg;

    localparam int unsigned IR_BITS_DEFAULT = 5;

    // IEEE 1149.1 TAP states with their fixed 4-bit visibility encodings
    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_e;

    // RISC-V debug transport instruction opcodes
    localparam logic [4:0] IDCODE     = 5'h01;
    localparam logic [4:0] DTM_CSR    = 5'h10;
    localparam logic [4:0] DMI_ACCESS = 5'h11;
    localparam logic [4:0] BYPASS     = 5'h1F;

    // One flag per state-qualified strobe; at most one is set at a time
    typedef struct packed {
        logic tlr_active;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
        logic capture_ir;
        logic shift_ir;
        logic update_ir;
    } tap_strobes_t;

    // TAP transition graph: next state for the sampled TMS
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    // Moore decode of a state into its strobes
    function automatic tap_strobes_t tap_decode(input tap_state_e s);
        tap_strobes_t d;
        d.tlr_active = (s == TLR);
        d.capture_dr = (s == CAP_DR);
        d.shift_dr   = (s == SH_DR);
        d.update_dr  = (s == UPD_DR);
        d.capture_ir = (s == CAP_IR);
        d.shift_ir   = (s == SH_IR);
        d.update_ir  = (s == UPD_IR);
        return d;
    endfunction

endpackage

// File: rtl/jtag_tap_controller_if.sv
// TAP controller bus: TMS/TDI from the probe side, instruction and strobes toward
// the TDO mux and DR chains.
interface jtag_tap_controller_if #(
    parameter int unsigned IR_BITS = jtag_pkg::IR_BITS_DEFAULT
) ();
    logic               TMS;
    logic               TDI;
    logic [IR_BITS-1:0] instr_reg_out;
    logic               ir_shift_out;
    logic               Shift_IR;
    logic               Shift_DR;
    logic               Capture_DR;
    logic               Update_DR;
    logic               Capture_IR;
    logic               Update_IR;
    logic               tlr_active;
    logic [3:0]         tap_state;

    // Probe / test-access side
    modport master (
        output TMS, TDI,
        input  instr_reg_out, ir_shift_out, Shift_IR, Shift_DR, Capture_DR,
               Update_DR, Capture_IR, Update_IR, tlr_active, tap_state
    );

    // TAP controller side
    modport slave (
        input  TMS, TDI,
        output instr_reg_out, ir_shift_out, Shift_IR, Shift_DR, Capture_DR,
               Update_DR, Capture_IR, Update_IR, tlr_active, tap_state
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// TAP state register with registered Moore strobes. The strobes are registered from
// the next state, so they line up exactly with the state they describe.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         tms,
    output tap_state_e   state,
    output tap_strobes_t strobes
);

    // State and strobe registers, synchronous reset into Test-Logic-Reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TLR;
            strobes <= tap_decode(TLR);
        end else begin
            state   <= tap_next(state, tms);
            strobes <= tap_decode(tap_next(state, tms));
        end
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller for the RISC-V debug port: TAP FSM plus the
// instruction shifter and the update (current instruction) register.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int unsigned        IR_BITS      = IR_BITS_DEFAULT,
    parameter logic [IR_BITS-1:0] IR_RESET_VAL = IR_BITS'(IDCODE),
    parameter logic [IR_BITS-1:0] IR_CAPT_VAL  = IR_BITS'(5'h01)
) (
    input  logic                  TCK,
    input  logic                  TRST,
    jtag_tap_controller_if.slave  bus
);

    tap_state_e         state;
    tap_strobes_t       strobes;
    logic [IR_BITS-1:0] ir_sh;
    logic [IR_BITS-1:0] instr;

    jtag_tap_fsm u_fsm (
        .clk     (TCK),
        .rst     (TRST),
        .tms     (bus.TMS),
        .state   (state),
        .strobes (strobes)
    );

    // IR shifter: parallel capture, then LSB-first shift with TDI entering at the MSB
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sh <= '0;
        end else if (state == CAP_IR) begin
            ir_sh <= IR_CAPT_VAL;
        end else if (state == SH_IR) begin
            ir_sh <= {bus.TDI, ir_sh[IR_BITS-1:1]};
        end
    end

    // Current instruction: loaded from the shifter in Update-IR, forced to IDCODE in TLR
    always_ff @(posedge TCK) begin
        if (TRST) begin
            instr <= IR_RESET_VAL;
        end else if (state == TLR) begin
            instr <= IR_RESET_VAL;
        end else if (state == UPD_IR) begin
            instr <= ir_sh;
        end
    end

    assign bus.instr_reg_out = instr;
    assign bus.ir_shift_out  = ir_sh[0];
    assign bus.tap_state     = 4'(state);
    assign bus.tlr_active    = strobes.tlr_active;
    assign bus.Capture_DR    = strobes.capture_dr;
    assign bus.Shift_DR      = strobes.shift_dr;
    assign bus.Update_DR     = strobes.update_dr;
    assign bus.Capture_IR    = strobes.capture_ir;
    assign bus.Shift_IR      = strobes.shift_ir;
    assign bus.Update_IR     = strobes.update_ir;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: directed scans plus a long random-TMS run,
// each cycle checked against an independent TAP/IR reference model.
module tb_jtag_tap_controller;

    logic TCK;
    logic TRST;

    jtag_tap_controller_if bus ();

    jtag_tap_controller dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    typedef struct {
        logic [3:0] st;
        logic [4:0] instr;
        logic       sh_out;
        logic [6:0] strb;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] m_st;
    logic [4:0] m_ir;
    logic [4:0] m_instr;
    bit         st_hit[16];
    bit         tr_hit[32];
    int         cnt_sh_dr;
    int         cnt_cap_dr;
    int         cnt_upd_dr;

    // Reference TAP graph written from the state table (TMS=0 / TMS=1)
    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic t);
        case (s)
            4'hF: return t ? 4'hF : 4'hC;
            4'hC: return t ? 4'h7 : 4'hC;
            4'h7: return t ? 4'h4 : 4'h6;
            4'h6: return t ? 4'h1 : 4'h2;
            4'h2: return t ? 4'h1 : 4'h2;
            4'h1: return t ? 4'h5 : 4'h3;
            4'h3: return t ? 4'h0 : 4'h3;
            4'h0: return t ? 4'h5 : 4'h2;
            4'h5: return t ? 4'h7 : 4'hC;
            4'h4: return t ? 4'hF : 4'hE;
            4'hE: return t ? 4'h9 : 4'hA;
            4'hA: return t ? 4'h9 : 4'hA;
            4'h9: return t ? 4'hD : 4'hB;
            4'hB: return t ? 4'h8 : 4'hB;
            4'h8: return t ? 4'hD : 4'hA;
            default: return t ? 4'h7 : 4'hC;
        endcase
    endfunction

    // {tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir}
    function automatic logic [6:0] ref_strb(input logic [3:0] s);
        return {s == 4'hF, s == 4'h6, s == 4'h2, s == 4'h5, s == 4'hE, s == 4'hA, s == 4'hD};
    endfunction

    function automatic logic [6:0] obs_strb();
        return {bus.tlr_active, bus.Capture_DR, bus.Shift_DR, bus.Update_DR,
                bus.Capture_IR, bus.Shift_IR, bus.Update_IR};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one TCK cycle, advance the model, then compare DUT against the queued expectation
    task automatic step(input logic r, input logic t, input logic d);
        exp_t e;
        TRST    = r;
        bus.TMS = t;
        bus.TDI = d;
        if (r) begin
            m_st    = 4'hF;
            m_ir    = 5'h00;
            m_instr = 5'h01;
        end else begin
            if (m_st == 4'hF)      m_instr = 5'h01;
            else if (m_st == 4'hD) m_instr = m_ir;
            if (m_st == 4'hE)      m_ir = 5'h01;
            else if (m_st == 4'hA) m_ir = {d, m_ir[4:1]};
            tr_hit[{m_st, t}] = 1'b1;
            m_st = ref_next(m_st, t);
        end
        st_hit[m_st] = 1'b1;
        e.st     = m_st;
        e.instr  = m_instr;
        e.sh_out = m_ir[0];
        e.strb   = ref_strb(m_st);
        sb.push_back(e);
        @(posedge TCK);
        #1;
        e = sb.pop_front();
        chk("model_state",  32'(bus.tap_state),     32'(e.st));
        chk("model_instr",  32'(bus.instr_reg_out), 32'(e.instr));
        chk("model_irout",  32'(bus.ir_shift_out),  32'(e.sh_out));
        chk("model_strobe", 32'(obs_strb()),        32'(e.strb));
        chk("strobe_onehot", 32'($countones(obs_strb()) <= 1), 32'd1);
        cnt_sh_dr  += int'(bus.Shift_DR);
        cnt_cap_dr += int'(bus.Capture_DR);
        cnt_upd_dr += int'(bus.Update_DR);
    endtask

    task automatic walk(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b0, s[i] == "1", 1'b0);
    endtask

    initial begin
        string      dr;
        logic [3:0] path [11];
        logic       ir_out_exp [5];
        logic [4:0] tdi_bits;
        int         n_st;
        int         n_tr;

        TRST    = 1'b1;
        bus.TMS = 1'b0;
        bus.TDI = 1'b0;
        m_st    = 4'hF;
        m_ir    = 5'h00;
        m_instr = 5'h01;

        // Reset: two cycles of TRST
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_state",   32'(bus.tap_state),        32'hF);
        chk("rst_tlr",     32'(bus.tlr_active),       32'd1);
        chk("rst_instr",   32'(bus.instr_reg_out),    32'h01);
        chk("rst_irout",   32'(bus.ir_shift_out),     32'd0);
        chk("rst_strobes", 32'(obs_strb() & 7'h3F),   32'd0);

        // IR load of 5'h11, LSB first
        walk("0");
        walk("1100");
        chk("irl_in_shift", 32'(bus.tap_state), 32'hA);
        tdi_bits   = 5'b10001;
        ir_out_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            chk("irl_irout", 32'(bus.ir_shift_out), 32'(ir_out_exp[i]));
            step(1'b0, i == 4, tdi_bits[i]);
        end
        chk("irl_ex1", 32'(bus.tap_state), 32'h9);
        step(1'b0, 1'b1, 1'b0);
        chk("irl_upd_pulse", 32'(bus.Update_IR),     32'd1);
        chk("irl_upd_old",   32'(bus.instr_reg_out), 32'h01);
        step(1'b0, 1'b0, 1'b0);
        chk("irl_upd_end",   32'(bus.Update_IR),     32'd0);
        chk("irl_instr",     32'(bus.instr_reg_out), 32'h11);

        // DR scan with pause: enter SH_DR and stay 3 cycles, then exit/pause/re-enter once
        cnt_sh_dr  = 0;
        cnt_cap_dr = 0;
        cnt_upd_dr = 0;
        dr   = "10000101011";
        path = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5};
        for (int i = 0; i < dr.len(); i++) begin
            step(1'b0, dr[i] == "1", 1'b0);
            chk("dr_path", 32'(bus.tap_state), 32'(path[i]));
        end
        chk("dr_shift_cycles", 32'(cnt_sh_dr),  32'd4);
        chk("dr_capture_cnt",  32'(cnt_cap_dr), 32'd1);
        chk("dr_update_cnt",   32'(cnt_upd_dr), 32'd1);
        walk("0");
        chk("dr_instr_kept", 32'(bus.instr_reg_out), 32'h11);

        // TMS reset from SH_DR: five TMS=1 edges reach TLR
        walk("100");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("tms_rst_walk", 32'(bus.tap_state == 4'hF), 32'(i == 4));
        end
        chk("tms_rst_tlr", 32'(bus.tlr_active), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("tms_rst_instr", 32'(bus.instr_reg_out), 32'h01);

        // TRST on the 3rd SH_IR bit while loading 5'h1F
        walk("01100");
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_rst_state", 32'(bus.tap_state),     32'hF);
        chk("mid_rst_instr", 32'(bus.instr_reg_out), 32'h01);
        chk("mid_rst_irout", 32'(bus.ir_shift_out),  32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk("mid_rst_no1f", 32'(bus.instr_reg_out), 32'h01);

        // Random TMS/TDI against the model
        for (int i = 0; i < 10000; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n_st = 0;
        n_tr = 0;
        foreach (st_hit[i]) if (st_hit[i]) n_st++;
        foreach (tr_hit[i]) if (tr_hit[i]) n_tr++;
        chk("cov_states",      32'(n_st), 32'd16);
        chk("cov_transitions", 32'(n_tr), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
